// File: rtl/viterbi_acs.sv
// Add-compare-select stage for a K=3, rate-1/2, (7,5) hard-decision Viterbi
// decoder. New path metrics are combinational back to the metric register
// stage; decisions, best state and frame strobes are registered for traceback.
module viterbi_acs #(
  parameter int W         = 8,
  parameter int NORM_THR  = 128,
  parameter int FRAME_LEN = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  input  logic [1:0]                   sym_i,
  input  logic [W-1:0]                 pm_cur_s0_i,
  input  logic [W-1:0]                 pm_cur_s1_i,
  input  logic [W-1:0]                 pm_cur_s2_i,
  input  logic [W-1:0]                 pm_cur_s3_i,
  output logic [W-1:0]                 pm_new_s0_o,
  output logic [W-1:0]                 pm_new_s1_o,
  output logic [W-1:0]                 pm_new_s2_o,
  output logic [W-1:0]                 pm_new_s3_o,
  output logic [3:0]                   dec_o,
  output logic [1:0]                   best_state_o,
  output logic                         norm_o,
  output logic [$clog2(FRAME_LEN)-1:0] step_cnt_o,
  output logic                         frame_end_o,
  output logic                         valid_o
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [W-1:0]  THR  = W'(NORM_THR);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [W-1:0] pm_cur [4];
  logic [W-1:0] sel    [4];
  logic [W-1:0] pm_new [4];
  logic [3:0]   dec_d;
  logic [1:0]   best_d;
  logic         norm_d;
  logic [W-1:0] min_val;

  logic [3:0]    dec_q;
  logic [1:0]    best_q;
  logic          norm_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fe_q, fe_d;
  logic          valid_q;

  assign pm_cur[0] = pm_cur_s0_i;
  assign pm_cur[1] = pm_cur_s1_i;
  assign pm_cur[2] = pm_cur_s2_i;
  assign pm_cur[3] = pm_cur_s3_i;

  // Branch symbol emitted when input bit u leaves predecessor {x1,x2}.
  function automatic logic [1:0] exp_sym(input logic u, input logic [1:0] p);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Saturating add keeps unreachable metrics pinned at all-ones.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {{(W-1){1'b0}}, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Add-compare-select per state; pb wins only when strictly smaller.
  always_comb begin
    logic [1:0]   pa, pb;
    logic [W-1:0] ca, cb;
    dec_d = '0;
    for (int n = 0; n < 4; n++) begin
      pa = {n[0], 1'b0};
      pb = {n[0], 1'b1};
      ca = sat_add(pm_cur[pa], hamming(sym_i, exp_sym(n[1], pa)));
      cb = sat_add(pm_cur[pb], hamming(sym_i, exp_sym(n[1], pb)));
      if (cb < ca) begin
        sel[n]   = cb;
        dec_d[n] = 1'b1;
      end else begin
        sel[n]   = ca;
      end
    end
  end

  // Minimum and argmin, lowest index kept on ties.
  always_comb begin
    min_val = sel[0];
    best_d  = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (sel[n] < min_val) begin
        min_val = sel[n];
        best_d  = 2'(n);
      end
    end
  end

  // Rebase all metrics once the smallest crosses the threshold.
  always_comb begin
    norm_d = (min_val >= THR);
    for (int n = 0; n < 4; n++) begin
      pm_new[n] = norm_d ? (sel[n] - THR) : sel[n];
    end
  end

  assign pm_new_s0_o = pm_new[0];
  assign pm_new_s1_o = pm_new[1];
  assign pm_new_s2_o = pm_new[2];
  assign pm_new_s3_o = pm_new[3];

  // Step counter wraps at the frame length; terminal count marks frame end.
  always_comb begin
    fe_d  = valid_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (valid_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Registered traceback outputs; reset wins over a concurrent valid step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      best_q  <= '0;
      norm_q  <= 1'b0;
      cnt_q   <= '0;
      fe_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      fe_q    <= fe_d;
      cnt_q   <= cnt_d;
      if (valid_i) begin
        dec_q  <= dec_d;
        best_q <= best_d;
        norm_q <= norm_d;
      end
    end
  end

  assign dec_o        = dec_q;
  assign best_state_o = best_q;
  assign norm_o       = norm_q;
  assign step_cnt_o   = cnt_q;
  assign frame_end_o  = fe_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_viterbi_acs.sv
// Bench for viterbi_acs: directed vectors, frame counting, mid-frame reset and
// a closed loop through a behavioural metric register driven by an encoder.
module tb_viterbi_acs;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic [1:0] sym_i;
  logic [7:0] dp [4];
  logic [7:0] lp [4];
  logic       use_loop;
  logic       lp_load;
  logic [7:0] c0, c1, c2, c3;
  logic [7:0] n0, n1, n2, n3;
  logic [3:0] dec_o;
  logic [1:0] best_state_o;
  logic       norm_o;
  logic [2:0] step_cnt_o;
  logic       frame_end_o;
  logic       valid_o;

  always #5 clk = ~clk;

  assign c0 = use_loop ? lp[0] : dp[0];
  assign c1 = use_loop ? lp[1] : dp[1];
  assign c2 = use_loop ? lp[2] : dp[2];
  assign c3 = use_loop ? lp[3] : dp[3];

  viterbi_acs #(.W(8), .NORM_THR(128), .FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i),
    .pm_cur_s0_i(c0), .pm_cur_s1_i(c1), .pm_cur_s2_i(c2), .pm_cur_s3_i(c3),
    .pm_new_s0_o(n0), .pm_new_s1_o(n1), .pm_new_s2_o(n2), .pm_new_s3_o(n3),
    .dec_o(dec_o), .best_state_o(best_state_o), .norm_o(norm_o),
    .step_cnt_o(step_cnt_o), .frame_end_o(frame_end_o), .valid_o(valid_o)
  );

  // Behavioural metric register closing the loop.
  always @(posedge clk) begin
    if (lp_load) begin
      lp[0] <= 8'd0; lp[1] <= 8'd255; lp[2] <= 8'd255; lp[3] <= 8'd255;
    end else if (valid_i && use_loop) begin
      lp[0] <= n0; lp[1] <= n1; lp[2] <= n2; lp[3] <= n3;
    end
  end

  typedef struct {
    logic [3:0] dec;
    logic [3:0] mask;
    logic [1:0] best;
    logic       norm;
    logic       fe;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int tb_cnt = 0;
  bit mon_en = 0;
  logic [3:0] hold_dec;
  logic [1:0] hold_best;
  logic       hold_norm;
  logic [2:0] hold_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop on each valid output, otherwise confirm registers hold.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got valid_o=1 expected empty scoreboard at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("dec", 32'(dec_o & e.mask), 32'(e.dec & e.mask));
          chk("best_state", 32'(best_state_o), 32'(e.best));
          chk("norm", 32'(norm_o), 32'(e.norm));
          chk("frame_end", 32'(frame_end_o), 32'(e.fe));
          chk("step_cnt", 32'(step_cnt_o), 32'(e.cnt));
          hold_dec  = dec_o;
          hold_best = e.best;
          hold_norm = e.norm;
          hold_cnt  = e.cnt;
        end
      end else begin
        chk("idle_frame_end", 32'(frame_end_o), 32'd0);
        chk("idle_dec_hold", 32'(dec_o), 32'(hold_dec));
        chk("idle_best_hold", 32'(best_state_o), 32'(hold_best));
        chk("idle_norm_hold", 32'(norm_o), 32'(hold_norm));
        chk("idle_cnt_hold", 32'(step_cnt_o), 32'(hold_cnt));
      end
    end
  end

  task automatic check_zero();
    chk("rst_dec", 32'(dec_o), 32'd0);
    chk("rst_best", 32'(best_state_o), 32'd0);
    chk("rst_norm", 32'(norm_o), 32'd0);
    chk("rst_cnt", 32'(step_cnt_o), 32'd0);
    chk("rst_frame_end", 32'(frame_end_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
  endtask

  task automatic after_reset();
    tb_cnt    = 0;
    hold_dec  = 4'd0;
    hold_best = 2'd0;
    hold_norm = 1'b0;
    hold_cnt  = 3'd0;
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset(input logic v);
    rst = 1'b1; valid_i = v;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    after_reset();
    check_zero();
  endtask

  task automatic step(input logic [7:0] p0, input logic [7:0] p1,
                      input logic [7:0] p2, input logic [7:0] p3,
                      input logic [1:0] s, input bit cpm,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3,
                      input logic [3:0] ed, input logic [3:0] em,
                      input logic [1:0] eb, input logic en, input int gap);
    exp_t e;
    dp[0] = p0; dp[1] = p1; dp[2] = p2; dp[3] = p3;
    sym_i = s; valid_i = 1'b1;
    #1;
    if (cpm) begin
      chk("pm_new_s0", 32'(n0), 32'(e0));
      chk("pm_new_s1", 32'(n1), 32'(e1));
      chk("pm_new_s2", 32'(n2), 32'(e2));
      chk("pm_new_s3", 32'(n3), 32'(e3));
    end
    e.dec = ed; e.mask = em; e.best = eb; e.norm = en;
    e.fe  = (tb_cnt == 7);
    tb_cnt = (tb_cnt + 1) % 8;
    e.cnt = 3'(tb_cnt);
    sb.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [1:0] st, ns, s;
    logic       u;
    int         waitc;
    rst = 1'b1; valid_i = 1'b0; sym_i = 2'b00; use_loop = 1'b0; lp_load = 1'b1;
    dp[0] = 0; dp[1] = 0; dp[2] = 0; dp[3] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; lp_load = 1'b0;
    after_reset();
    check_zero();
    mon_en = 1'b1;

    // Directed ACS vectors.
    step(0, 255, 255, 255, 2'b00, 1, 0, 255, 2, 255, 4'b0000, 4'hF, 2'd0, 0, 1);
    step(0, 255, 2, 255,   2'b11, 1, 2, 3, 0, 3,     4'b0000, 4'hF, 2'd2, 0, 0);
    step(10, 10, 10, 10,   2'b01, 1, 11, 10, 11, 10, 4'b0010, 4'hF, 2'd1, 0, 2);
    step(200, 210, 220, 230, 2'b00, 1, 72, 93, 74, 93, 4'b0000, 4'hF, 2'd0, 1, 0);
    step(127, 200, 200, 200, 2'b00, 1, 127, 201, 129, 201, 4'b0000, 4'hF, 2'd0, 0, 1);
    step(128, 200, 200, 200, 2'b00, 1, 0, 73, 2, 73, 4'b0000, 4'hF, 2'd0, 1, 0);
    step(5, 3, 9, 9,       2'b11, 1, 3, 10, 5, 10,   4'b0001, 4'hF, 2'd0, 0, 1);

    // Full frame with random idle gaps.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++)
      step(0, 255, 255, 255, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 2'd0, 0, $urandom_range(0, 3));

    // Reset mid-frame while a step is offered.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++)
      step(10, 10, 10, 10, 2'b01, 0, 0, 0, 0, 0, 4'b0010, 4'hF, 2'd1, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 8; i++)
      step(0, 255, 2, 255, 2'b11, 0, 0, 0, 0, 0, 4'b0000, 4'hF, 2'd2, 0, $urandom_range(0, 1));

    // Closed loop with an error-free encoded stream.
    do_reset(1'b0);
    lp_load = 1'b1;
    @(posedge clk); #1;
    lp_load = 1'b0; use_loop = 1'b1;
    st = 2'b00;
    for (int i = 0; i < 64; i++) begin
      u  = 1'($urandom_range(0, 1));
      s  = {u ^ st[1] ^ st[0], u ^ st[0]};
      ns = {u, st[1]};
      step(0, 0, 0, 0, s, 0, 0, 0, 0, 0,
           4'(st[0]) << ns, 4'b0001 << ns, ns, 1'b0, $urandom_range(0, 1));
      st = ns;
    end

    waitc = 0;
    while (sb.size() != 0 && waitc < 20) begin @(posedge clk); waitc++; end
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
